// File: rtl/arb_pkg.sv
// Shared types, sizing helper and reset values for the request/grant arbiters.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } arb_state_t;

    // Width for an index/counter over n values; never returns 0 so ports stay legal.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam arb_state_t ARB_RST_STATE   = IDLE;
    localparam logic       ARB_RST_BUSY    = 1'b0;
    localparam logic       ARB_RST_TIMEOUT = 1'b0;

endpackage

// File: rtl/arb_property.sv
// Per-channel req/gnt contract checks, attached to every arbiter instance via bind.
module arb_property
    import arb_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int MAX_HOLD = 8
) (
    input logic              clk,
    input logic              rst,
    input logic [NUM_CH-1:0] req,
    input logic [NUM_CH-1:0] gnt,
    input logic              busy
);

    localparam int RW = clog2_safe(MAX_HOLD + 2);

    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;

    // Saturating count of consecutive sampled gnt-high cycles.
    always_comb begin
        run_d = '0;
        if (|gnt) begin
            run_d = (run_q == RW'(MAX_HOLD + 1)) ? run_q : run_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_busy:   assert property (@(posedge clk) disable iff (rst) (|gnt) |-> busy);
    a_hold:   assert property (@(posedge clk) disable iff (rst) run_q <= RW'(MAX_HOLD));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        a_req_gnt: assert property (@(posedge clk) disable iff (rst) gnt[i] |-> $past(req[i]));
    end

endmodule

bind rr_req_gnt_arbiter arb_property #(
    .NUM_CH   (NUM_CH),
    .MAX_HOLD (MAX_HOLD)
) u_arb_property (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .busy (busy)
);

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping to 0.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]             req,
    input  logic [clog2_safe(NUM_CH)-1:0] ptr,
    output logic [clog2_safe(NUM_CH)-1:0] winner,
    output logic                          any_req
);

    localparam int IW = clog2_safe(NUM_CH);
    // One spare bit so ptr + offset (at most 2*NUM_CH-2) never overflows before the wrap.
    localparam int JW = IW + 1;

    logic [JW-1:0] j;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        j       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = {1'b0, ptr} + JW'(i);
            if (j >= JW'(NUM_CH)) begin
                j = j - JW'(NUM_CH);
            end
            if (!any_req && req[j[IW-1:0]]) begin
                any_req = 1'b1;
                winner  = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin arbiter granting one of NUM_CH level requesters after GNT_DELAY edges,
// holding at most MAX_HOLD cycles and flagging a forced release with timeout_err.
module rr_req_gnt_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int GNT_DELAY = 2,
    parameter int MAX_HOLD  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req,
    output logic [NUM_CH-1:0]         gnt,
    output logic [$clog2(NUM_CH)-1:0] gnt_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IW = clog2_safe(NUM_CH);
    localparam int CW = clog2_safe(GNT_DELAY + 1);
    localparam int HW = clog2_safe(MAX_HOLD + 1);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              to_q, to_d;

    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [IW-1:0]     ptr_next;
    logic              req_win;

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    // Explicit wrap keeps the increment correct for non-power-of-2 NUM_CH.
    assign ptr_next = (win_q == IW'(NUM_CH - 1)) ? '0 : win_q + 1'b1;
    assign req_win  = req[win_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_any) begin
                    win_d  = pick_idx;
                    busy_d = 1'b1;
                    if (GNT_DELAY == 1) begin
                        state_d = GRANT;
                        gnt_d   = NUM_CH'(1) << pick_idx;
                        hold_d  = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT: begin
                if (!req_win) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                end else if (cnt_q == CW'(GNT_DELAY - 1)) begin
                    state_d = GRANT;
                    gnt_d   = NUM_CH'(1) << win_q;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GRANT: begin
                if (!req_win) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                end else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    // hold_q counts from 0, so this edge ends the MAX_HOLD-th high cycle.
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    to_d    = 1'b1;
                    ptr_d   = ptr_next;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_RST_STATE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            busy_q  <= ARB_RST_BUSY;
            to_q    <= ARB_RST_TIMEOUT;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = win_q;
    assign busy        = busy_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Directed plus random stimulus against an edge-level behavioural model of the arbiter;
// a second instance covers the zero-wait (GNT_DELAY=1) build.
module tb_rr_req_gnt_arbiter;

    localparam int NUM_CH    = 4;
    localparam int GNT_DELAY = 2;
    localparam int MAX_HOLD  = 8;

    logic       clk = 1'b0;
    logic       rst, rst1;
    logic [3:0] req, req1;
    logic [3:0] gnt, gnt1;
    logic [1:0] gnt_id, gnt_id1;
    logic       busy, busy1, timeout_err, timeout_err1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rr_req_gnt_arbiter #(.NUM_CH(NUM_CH), .GNT_DELAY(GNT_DELAY), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id),
        .busy(busy), .timeout_err(timeout_err));

    rr_req_gnt_arbiter #(.NUM_CH(NUM_CH), .GNT_DELAY(1), .MAX_HOLD(MAX_HOLD)) dut1 (
        .clk(clk), .rst(rst1), .req(req1), .gnt(gnt1), .gnt_id(gnt_id1),
        .busy(busy1), .timeout_err(timeout_err1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model (per edge, from the stated rules) ----------------
    int m_busy, m_gnt_on, m_win, m_ptr, m_age, m_held, m_to;
    initial begin
        m_busy = 0; m_gnt_on = 0; m_win = 0; m_ptr = 0; m_age = 0; m_held = 0; m_to = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_gnt_on = 0; m_win = 0; m_ptr = 0; m_age = 0; m_held = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_busy == 0) begin
                if (req != 4'b0) begin
                    int found;
                    found = 0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (found == 0 && req[2'((m_ptr + k) % NUM_CH)]) begin
                            found = 1;
                            m_win = (m_ptr + k) % NUM_CH;
                        end
                    end
                    m_busy = 1;
                    m_age  = 1;
                    if (m_age == GNT_DELAY) begin
                        m_gnt_on = 1; m_held = 1;
                    end
                end
            end else if (!req[2'(m_win)]) begin
                m_busy = 0; m_gnt_on = 0; m_ptr = (m_win + 1) % NUM_CH;
            end else if (m_gnt_on != 0) begin
                if (m_held == MAX_HOLD) begin
                    m_busy = 0; m_gnt_on = 0; m_to = 1; m_ptr = (m_win + 1) % NUM_CH;
                end else begin
                    m_held++;
                end
            end else begin
                m_age++;
                if (m_age == GNT_DELAY) begin
                    m_gnt_on = 1; m_held = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_gnt", int'(gnt), (m_gnt_on != 0) ? (1 << m_win) : 0);
            chk("model_busy", int'(busy), m_busy);
            chk("model_timeout_err", int'(timeout_err), m_to);
            if (m_busy != 0) chk("model_gnt_id", int'(gnt_id), m_win);
        end
    end

    task automatic wait_gnt(output logic [3:0] g);
        int n = 0;
        while (gnt == 4'b0 && n < 20) begin
            step(1);
            n++;
        end
        if (gnt == 4'b0) chk("wait_gnt_timeout", 0, 1);
        g = gnt;
    endtask

    // ---------------- main directed + random sequence ----------------
    initial begin
        logic [3:0] g;
        int n;
        rst = 1'b1; req = 4'b0;
        step(1);
        chk_en = 1'b1;
        step(1);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gnt_id", int'(gnt_id), 0);
        chk("rst_timeout", int'(timeout_err), 0);
        rst = 1'b0;

        // single channel
        req = 4'b0010;
        step(1);
        chk("t1_busy_e0", int'(busy), 1);
        chk("t1_id_e0", int'(gnt_id), 1);
        chk("t1_gnt_e0", int'(gnt), 0);
        step(1);
        chk("t1_gnt_e1", int'(gnt), 2);
        step(2);
        req = 4'b0;
        step(1);
        chk("t1_gnt_e4", int'(gnt), 0);

        // round robin
        rst = 1'b1; step(1); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req = 4'hF;
            wait_gnt(g);
            chk("t2_rr_order", int'(g), 1 << (k % 4));
            step(1);
            req = 4'hF & ~g;
            step(1);
            chk("t2_rr_gap", int'(gnt), 0);
        end
        req = 4'b0; step(3);

        // timeout
        req = 4'b0100;
        wait_gnt(g);
        n = 1;
        step(1);
        while (gnt == 4'b0100 && n < 20) begin
            n++;
            step(1);
        end
        chk("t3_hold_cycles", n, 8);
        chk("t3_timeout_pulse", int'(timeout_err), 1);
        chk("t3_gnt_fall", int'(gnt), 0);
        step(1);
        chk("t3_timeout_once", int'(timeout_err), 0);
        chk("t3_recapture_busy", int'(busy), 1);
        chk("t3_idle_gap", int'(gnt), 0);
        step(1);
        chk("t3_regrant_ch2", int'(gnt), 4);
        req = 4'b0101;
        n = 0;
        while (!timeout_err && n < 20) begin
            step(1);
            n++;
        end
        chk("t3_second_timeout", int'(timeout_err), 1);
        wait_gnt(g);
        chk("t3_next_ch0", int'(g), 1);
        req = 4'b0; step(3);

        // abandon
        req = 4'b1000;
        step(1);
        chk("t4_capture_busy", int'(busy), 1);
        chk("t4_capture_id", int'(gnt_id), 3);
        req = 4'b0;
        step(1);
        chk("t4_abandon_busy", int'(busy), 0);
        chk("t4_abandon_gnt", int'(gnt), 0);
        req = 4'b1001;
        wait_gnt(g);
        chk("t4_wrap_ch0", int'(g), 1);
        req = 4'b0; step(2);

        // reset mid-grant
        req = 4'b1000;
        wait_gnt(g);
        step(2);
        chk("t5_third_cycle", int'(gnt), 8);
        rst = 1'b1;
        step(1);
        chk("t5_rst_gnt", int'(gnt), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_id", int'(gnt_id), 0);
        chk("t5_rst_timeout", int'(timeout_err), 0);
        rst = 1'b0; req = 4'b0010;
        wait_gnt(g);
        chk("t5_after_rst_ch1", int'(g), 2);
        req = 4'b0; step(2);

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 99) == 0);
            step(1);
        end
        rst = 1'b0; req = 4'b0;
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- GNT_DELAY=1 build ----------------
    initial begin
        int n;
        rst1 = 1'b1; req1 = 4'b0;
        step(2);
        rst1 = 1'b0;
        req1 = 4'b0001;
        step(1);
        chk("d1_gnt_e0", int'(gnt1), 1);
        chk("d1_busy_e0", int'(busy1), 1);
        chk("d1_id_e0", int'(gnt_id1), 0);
        n = 1;
        step(1);
        while (gnt1 == 4'b0001 && n < 20) begin
            n++;
            step(1);
        end
        chk("d1_hold_cycles", n, 8);
        chk("d1_timeout", int'(timeout_err1), 1);
        req1 = 4'b0;
    end

endmodule

// File: doc/rr_req_gnt_arbiter.md
Name: rr_req_gnt_arbiter

Overview:
Multi-channel successor to the single-channel req/gnt handshake block. It arbitrates NUM_CH requesters onto one shared resource with round-robin fairness. Grant latency and maximum grant hold time are parametrised, and there is timeout reporting. Each gnt line has the same req→gnt contract as the single-channel block, so the existing bind-style property checkers can be instantiated per channel.

Parameters:
NUM_CH, 4, number of requester channels (≥2)
GNT_DELAY, 2, rising edges from request capture to gnt high, counting the capture edge as the 1st (≥1)
MAX_HOLD, 8, maximum consecutive cycles gnt may stay high (≥1)

Ports:
clk  input  1  single clock; all logic on its rising edge
rst  input  1  reset, synchronous, active-high
req  input  NUM_CH  per-channel request, level-sensitive
gnt  output  NUM_CH  per-channel grant, one-hot or zero, registered
gnt_id  output  $clog2(NUM_CH)  index of current/pending winner, valid while busy=1
busy  output  1  high in WAIT or GRANT
timeout_err  output  1  one-cycle pulse when a grant is revoked at MAX_HOLD

Behaviour:
- Reset: any rising edge with rst=1 gives gnt=0, gnt_id=0, busy=0, timeout_err=0, state=IDLE, rr pointer=0, counters=0. This applies mid-WAIT or mid-GRANT; the grant is dropped the next cycle with no timeout pulse.
- States: IDLE, WAIT, GRANT. All outputs are registered.
- IDLE: on an edge where req≠0, the winner w is the first set bit at or after the pointer, scanning upward and wrapping at NUM_CH-1→0. Capture w into gnt_id and set busy=1.
  - If GNT_DELAY=1: go straight to GRANT and set gnt[w]=1 on this same edge.
  - Otherwise: go to WAIT with delay count = 1.
- WAIT: each edge increments the count.
  - When the count reaches GNT_DELAY-1 and req[w]=1: go to GRANT, gnt[w]=1. gnt is therefore first visible after the GNT_DELAY-th edge.
  - If req[w]=0 on any WAIT edge: abandon, go to IDLE, busy=0, no grant, pointer=(w+1) mod NUM_CH.
- GRANT: hold_cnt starts at 0 and increments on each edge that stays in GRANT.
  - req[w]=0 at an edge: gnt=0, busy=0, go to IDLE, pointer=(w+1) mod NUM_CH.
  - Else if hold_cnt=MAX_HOLD-1: gnt=0, busy=0, timeout_err=1 for exactly one cycle, go to IDLE, pointer advances.
  - Net effect: gnt stays high for at most MAX_HOLD cycles.
- Requests from other channels during WAIT/GRANT are ignored (not latched). They are re-evaluated only in IDLE.
- Minimum one IDLE cycle between consecutive grants (gnt low ≥1 cycle). Back-to-back grants never go to the same channel if another channel is requesting.
- Pointer wrap: after w=NUM_CH-1 the pointer becomes 0. Use a width-safe modulo for non-power-of-2 NUM_CH.
- Invariants: $onehot0(gnt); gnt[i] high implies req[i] was high on the previous edge; gnt never rises in IDLE except when GNT_DELAY=1.

Decomposition:
- Package arb_pkg:
  - state enum typedef arb_state_t {IDLE, WAIT, GRANT}
  - function clog2_safe (returns ≥1)
  - reset-value constants
- Sub-module rr_pick: combinational rotate-priority encoder. Inputs req, ptr; outputs winner index and any_req. Reused by future arbiters.
- Property module arb_property (per-channel req/gnt latency checks, onehot, max-hold) is bound to the top.

Test Plan:
All with NUM_CH=4, GNT_DELAY=2, MAX_HOLD=8.
1. Single channel: req=4'b0010 held from edge 0 → busy=1, gnt_id=1 after edge 0; gnt=4'b0010 after edge 1. Drop req before edge 4 → gnt=0 after edge 4.
2. Round robin: req=4'b1111 held continuously, each grant released by dropping that channel's req for one cycle after 2 grant cycles → grant order 0,1,2,3,0. ≥1 gnt-low cycle between each.
3. Timeout: req=4'b0100 held forever → gnt[2] high exactly 8 cycles; timeout_err one-cycle pulse coincident with gnt falling. Next grant to ch2 only after IDLE, and only when no other channel is requesting.
4. Abandon: req[3] asserted for one cycle only → capture in IDLE, WAIT sees req[3]=0 → no gnt ever, busy falls. Next req=4'b1001 → grant ch0 (pointer wrapped to 0).
5. Reset mid-grant: rst=1 on the 3rd gnt-high cycle → all outputs 0 after that edge, no timeout_err. After rst=0 with req=4'b0010 → ch1 granted (pointer reset to 0, ch0 idle).
6. GNT_DELAY=1 build: req=4'b0001 at edge 0 → gnt=4'b0001 immediately after edge 0; no WAIT state visited.
